// File: rtl/two_ops_stream_acc.sv
// two_ops_stream_acc
//
// Window accumulator for the unsigned result stream of the two-op (add then
// subtract) datapath. Every COUNT accepted samples are summed into one
// SUM_WIDTH-bit total. That total is presented on a valid/ready output port
// and held there until the sink accepts it.
//
// Optional feature (compile-time macro):
//   TWO_OPS_STREAM_ACC_SAT_EN - when defined, each accumulation step
//   saturates at all ones instead of wrapping modulo 2^SUM_WIDTH. Ports and
//   timing are identical in both builds.
//
// Flow control: while a finished window is held, I_READY follows O_READY
// combinationally. A ready sink therefore lets the next sample in during the
// same cycle that the held total leaves, and the stream keeps one sample per
// cycle without a bubble.

module two_ops_stream_acc #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int SUM_WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_VALID,
    output logic                 I_READY,
    output logic [SUM_WIDTH-1:0] O,
    output logic                 O_VALID,
    input  logic                 O_READY,
    output logic [7:0]           CNT
);

    // Reject parameter sets the 8-bit CNT port or the arithmetic cannot represent
    if (COUNT < 1 || COUNT > 256) begin : g_bad_count
        $error("two_ops_stream_acc: COUNT must be in 1..256");
    end
    if (SUM_WIDTH < WIDTH) begin : g_bad_width
        $error("two_ops_stream_acc: SUM_WIDTH must be at least WIDTH");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // CNT value of the sample that closes a window
    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

    state_t               state_q, state_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0] o_q, o_d;
    logic                 o_valid_q, o_valid_d;

    logic                 i_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic [SUM_WIDTH-1:0] sample_ext;
    logic [SUM_WIDTH-1:0] sum_next;

    // Adds one sample to the running total, either wrapping or clamping at all ones
    function automatic logic [SUM_WIDTH-1:0] add_step(
        input logic [SUM_WIDTH-1:0] a,
        input logic [SUM_WIDTH-1:0] b
    );
`ifdef TWO_OPS_STREAM_ACC_SAT_EN
        logic [SUM_WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[SUM_WIDTH]) begin
            return '1;
        end
        return wide[SUM_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Handshake decode and next-state computation for the accumulate/hold FSM
    always_comb begin
        i_ready    = !o_valid_q || O_READY;
        in_fire    = I_VALID && i_ready;
        out_fire   = o_valid_q && O_READY;
        sample_ext = SUM_WIDTH'(I);
        sum_next   = add_step(acc_q, sample_ext);

        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        o_d        = o_q;
        o_valid_d  = o_valid_q;

        if (out_fire) begin
            o_valid_d = 1'b0;
            state_d   = ACCUM;
        end

        if (in_fire) begin
            if (cnt_q == LAST_CNT) begin
                o_d       = sum_next;
                o_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = HOLD;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Register all state; reset throws away any partial window and any held total
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Drive the ports from the registered state
    always_comb begin
        I_READY = i_ready;
        O       = o_q;
        O_VALID = o_valid_q;
        CNT     = cnt_q;
    end

endmodule

// File: tb/tb_two_ops_stream_acc.sv
// Self-checking bench for two_ops_stream_acc.
// Three instances are used: the default configuration (COUNT=4, SUM_WIDTH=10),
// a narrow-sum build (SUM_WIDTH=9) that exercises wrap or saturation, and a
// COUNT=1 build. A window-sum model pushes each expected total when the
// closing sample is accepted. The total is popped when the DUT hands it over.

module tb_two_ops_stream_acc;

   logic       clk;
   logic       reset;

   logic [7:0] aI, bI, cI;
   logic       aValid, bValid, cValid;
   logic       aReady, bReady, cReady;
   logic       aOReady, bOReady, cOReady;
   logic       aOValid, bOValid, cOValid;
   logic [9:0] aO;
   logic [8:0] bO;
   logic [9:0] cO;
   logic [7:0] aCnt, bCnt, cCnt;

   int checkCount = 0;
   int failCount  = 0;

   logic [31:0] sbQ0[$];
   logic [31:0] sbQ1[$];
   logic [31:0] sbQ2[$];
   logic [31:0] modelAcc[3];
   logic [31:0] modelCnt[3];

   two_ops_stream_acc #(.WIDTH(8), .COUNT(4), .SUM_WIDTH(10)) dutA (
      .CLK(clk), .RESET(reset), .I(aI), .I_VALID(aValid), .I_READY(aReady),
      .O(aO), .O_VALID(aOValid), .O_READY(aOReady), .CNT(aCnt)
   );

   two_ops_stream_acc #(.WIDTH(8), .COUNT(4), .SUM_WIDTH(9)) dutB (
      .CLK(clk), .RESET(reset), .I(bI), .I_VALID(bValid), .I_READY(bReady),
      .O(bO), .O_VALID(bOValid), .O_READY(bOReady), .CNT(bCnt)
   );

   two_ops_stream_acc #(.WIDTH(8), .COUNT(1), .SUM_WIDTH(10)) dutC (
      .CLK(clk), .RESET(reset), .I(cI), .I_VALID(cValid), .I_READY(cReady),
      .O(cO), .O_VALID(cOValid), .O_READY(cOReady), .CNT(cCnt)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int countOf(input int id);
      return (id == 2) ? 1 : 4;
   endfunction

   function automatic logic [31:0] maskOf(input int id);
      return (id == 1) ? 32'd511 : 32'd1023;
   endfunction

   function automatic int qSize(input int id);
      case (id)
         0:       return sbQ0.size();
         1:       return sbQ1.size();
         default: return sbQ2.size();
      endcase
   endfunction

   function automatic logic [31:0] qFront(input int id);
      case (id)
         0:       return sbQ0[0];
         1:       return sbQ1[0];
         default: return sbQ2[0];
      endcase
   endfunction

   task automatic qPop(input int id);
      logic [31:0] dummy;
      case (id)
         0:       dummy = sbQ0.pop_front();
         1:       dummy = sbQ1.pop_front();
         default: dummy = sbQ2.pop_front();
      endcase
   endtask

   task automatic qPush(input int id, input logic [31:0] v);
      case (id)
         0:       sbQ0.push_back(v);
         1:       sbQ1.push_back(v);
         default: sbQ2.push_back(v);
      endcase
   endtask

   // Window-sum reference: one accumulation step, wrapping or saturating
   function automatic logic [31:0] modelAdd(input int id, input logic [31:0] acc, input logic [7:0] s);
      logic [31:0] sum;
      sum = acc + 32'(s);
`ifdef TWO_OPS_STREAM_ACC_SAT_EN
      if (sum > maskOf(id)) sum = maskOf(id);
`else
      sum = sum & maskOf(id);
`endif
      return sum;
   endfunction

   // Per-cycle scoreboard step for one instance, evaluated at the falling edge
   task automatic scoreStep(input int id, input logic valid, input logic ready, input logic [7:0] sample,
                            input logic oValid, input logic oReady, input logic [31:0] o, input logic [31:0] cnt);
      string nm;
      logic  expReady;
      nm = (id == 0) ? "A" : (id == 1) ? "B" : "C";
      expReady = (qSize(id) == 0) || oReady;
      checkOutput({"oValid", nm}, 32'(oValid), 32'(qSize(id) != 0));
      checkOutput({"iReady", nm}, 32'(ready), 32'(expReady));
      checkOutput({"cnt", nm}, cnt, modelCnt[id]);
      if (qSize(id) != 0 && oValid) begin
         checkOutput({"sum", nm}, o, qFront(id));
         if (oReady) qPop(id);
      end
      if (valid && ready) begin
         modelAcc[id] = modelAdd(id, modelAcc[id], sample);
         modelCnt[id] = modelCnt[id] + 1;
         if (modelCnt[id] == 32'(countOf(id))) begin
            qPush(id, modelAcc[id]);
            modelAcc[id] = 0;
            modelCnt[id] = 0;
         end
      end
   endtask

   // Monitor: clears the model under reset, otherwise scores all three instances
   always @(negedge clk) begin
      if (reset) begin
         sbQ0.delete();
         sbQ1.delete();
         sbQ2.delete();
         for (int k = 0; k < 3; k++) begin
            modelAcc[k] = 0;
            modelCnt[k] = 0;
         end
      end else begin
         scoreStep(0, aValid, aReady, aI, aOValid, aOReady, 32'(aO), 32'(aCnt));
         scoreStep(1, bValid, bReady, bI, bOValid, bOReady, 32'(bO), 32'(bCnt));
         scoreStep(2, cValid, cReady, cI, cOValid, cOReady, 32'(cO), 32'(cCnt));
      end
   end

   task automatic setIn(input int id, input logic v, input logic [7:0] d);
      case (id)
         0:       begin aValid = v; aI = d; end
         1:       begin bValid = v; bI = d; end
         default: begin cValid = v; cI = d; end
      endcase
   endtask

   task automatic setOReady(input int id, input logic v);
      case (id)
         0:       aOReady = v;
         1:       bOReady = v;
         default: cOReady = v;
      endcase
   endtask

   function automatic logic getReady(input int id);
      case (id)
         0:       return aReady;
         1:       return bReady;
         default: return cReady;
      endcase
   endfunction

   // Drive one sample and hold it until accepted; a stalled sink is released after a few cycles
   task automatic applyStimulus(input int id, input logic [7:0] value);
      int waitCycles;
      waitCycles = 0;
      setIn(id, 1'b1, value);
      forever begin
         @(negedge clk);
         if (getReady(id)) break;
         waitCycles++;
         if (waitCycles == 3) setOReady(id, 1'b1);
         if (waitCycles > 40) begin
            checkOutput("readyWait", 32'(getReady(id)), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      setIn(id, 1'b0, 8'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Directed test plan followed by randomized traffic
   initial begin
      reset = 1'b1;
      aI = 0; bI = 0; cI = 0;
      aValid = 0; bValid = 0; cValid = 0;
      aOReady = 1; bOReady = 1; cOReady = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("resetO", 32'(aO), 32'd0);
      checkOutput("resetOValid", 32'(aOValid), 32'd0);
      checkOutput("resetCnt", 32'(aCnt), 32'd0);
      checkOutput("resetReady", 32'(aReady), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] basic window");
      applyStimulus(0, 8'd10);
      applyStimulus(0, 8'd20);
      applyStimulus(0, 8'd30);
      applyStimulus(0, 8'd40);
      idle(3);

      $display("[TB] backpressure");
      applyStimulus(0, 8'd1);
      applyStimulus(0, 8'd2);
      applyStimulus(0, 8'd3);
      applyStimulus(0, 8'd4);
      aOReady = 1'b0;
      setIn(0, 1'b1, 8'd99);
      repeat (5) begin
         @(negedge clk);
         checkOutput("stallO", 32'(aO), 32'd10);
         checkOutput("stallCnt", 32'(aCnt), 32'd0);
      end
      @(posedge clk);
      #1;
      aOReady = 1'b1;
      applyStimulus(0, 8'd7);
      @(negedge clk);
      checkOutput("afterOutValid", 32'(aOValid), 32'd0);
      checkOutput("afterOutCnt", 32'(aCnt), 32'd1);
      applyStimulus(0, 8'd1);
      applyStimulus(0, 8'd1);
      applyStimulus(0, 8'd1);
      idle(3);

      $display("[TB] zero-bubble streaming");
      for (int i = 0; i < 8; i++) applyStimulus(0, 8'd5);
      idle(3);

      $display("[TB] reset mid-window");
      applyStimulus(0, 8'd50);
      applyStimulus(0, 8'd60);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("cntAfterReset", 32'(aCnt), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'd1);
      idle(3);

      $display("[TB] wrap or saturate on 9-bit sum");
      for (int i = 0; i < 4; i++) applyStimulus(1, 8'd255);
      @(negedge clk);
`ifdef TWO_OPS_STREAM_ACC_SAT_EN
      checkOutput("narrowSum", 32'(bO), 32'd511);
`else
      checkOutput("narrowSum", 32'(bO), 32'd508);
`endif
      idle(3);

      $display("[TB] COUNT=1 back-to-back");
      applyStimulus(2, 8'd3);
      applyStimulus(2, 8'd9);
      applyStimulus(2, 8'd200);
      idle(3);

      $display("[TB] random traffic with sink stalls");
      for (int i = 0; i < 40; i++) begin
         aOReady = 1'($urandom_range(0, 1));
         bOReady = 1'($urandom_range(0, 1));
         applyStimulus(0, 8'($urandom_range(0, 255)));
         applyStimulus(1, 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      aOReady = 1'b1;
      bOReady = 1'b1;
      idle(6);

      checkOutput("drainA", 32'(qSize(0)), 32'd0);
      checkOutput("drainB", 32'(qSize(1)), 32'd0);
      checkOutput("drainC", 32'(qSize(2)), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
